sprite_compositor: RTL and testbench

//  Final pixel stage between the transparent-sprite layers and the video encoder.

---
 rtl/sprite_compositor_if.sv | 43 ++++
 rtl/sprite_compositor.sv | 135 +++++++++++++
 tb/tb_sprite_compositor.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/sprite_compositor_if.sv
// Pixel-side bundle for the sprite compositor: raw video timing, the
// late-arriving background/sprite pixels, and the composited outputs.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4
);
    logic [10:0]              hcount_in;
    logic [9:0]               vcount_in;
    logic                     hsync_in;
    logic                     vsync_in;
    logic                     active_draw_in;
    logic                     new_frame_in;
    logic [23:0]              bg_rgb_in;
    logic [NUM_LAYERS*24-1:0] layer_rgb_in;
    logic [NUM_LAYERS-1:0]    layer_valid_in;

    logic [7:0]               red_out;
    logic [7:0]               green_out;
    logic [7:0]               blue_out;
    logic                     hsync_out;
    logic                     vsync_out;
    logic                     active_draw_out;
    logic [NUM_LAYERS-1:0]    collision_mask_out;
    logic                     collision_frame_out;
    logic [15:0]              collision_count_out;

    // Video source side: drives timing and pixels, receives the composite.
    modport master (
        output hcount_in, vcount_in, hsync_in, vsync_in, active_draw_in,
               new_frame_in, bg_rgb_in, layer_rgb_in, layer_valid_in,
        input  red_out, green_out, blue_out, hsync_out, vsync_out,
               active_draw_out, collision_mask_out, collision_frame_out,
               collision_count_out
    );

    // Compositor side.
    modport slave (
        input  hcount_in, vcount_in, hsync_in, vsync_in, active_draw_in,
               new_frame_in, bg_rgb_in, layer_rgb_in, layer_valid_in,
        output red_out, green_out, blue_out, hsync_out, vsync_out,
               active_draw_out, collision_mask_out, collision_frame_out,
               collision_count_out
    );
endinterface

// File: rtl/sprite_compositor.sv
// Final pixel stage: merges sprite layers over the background by fixed
// priority (layer 0 on top), realigns the raw video timing with the sprite
// pipeline latency, and reports per-frame overlaps between layer 0 (the
// player sprite) and every other layer.
//
// Stage "A" is the cycle where raw timing delayed by SYNC_DELAY lines up with
// the incoming pixels. Everything leaving the block is registered once after
// stage A. The raw hcount/vcount travel in the bundle for upstream use only;
// no decision here depends on the pixel position, so they are not delayed.
module sprite_compositor #(
    parameter int NUM_LAYERS = 4,
    parameter int SYNC_DELAY = 4
) (
    input  logic              pixel_clk_in,
    input  logic              rst_n_in,
    sprite_compositor_if.slave vid
);

    logic [SYNC_DELAY-1:0] hsync_sh;
    logic [SYNC_DELAY-1:0] vsync_sh;
    logic [SYNC_DELAY-1:0] active_sh;
    logic [SYNC_DELAY-1:0] new_frame_sh;

    logic a_hsync;
    logic a_vsync;
    logic a_active;
    logic a_new_frame;

    logic [23:0]           pix_sel;
    logic [NUM_LAYERS-1:0] contrib;
    logic [NUM_LAYERS-1:0] acc;

    logic [23:0]           rgb_q;
    logic                  hsync_q;
    logic                  vsync_q;
    logic                  active_q;
    logic [NUM_LAYERS-1:0] mask_q;
    logic                  frame_q;
    logic [15:0]           count_q;

    assign a_hsync     = hsync_sh[SYNC_DELAY-1];
    assign a_vsync     = vsync_sh[SYNC_DELAY-1];
    assign a_active    = active_sh[SYNC_DELAY-1];
    assign a_new_frame = new_frame_sh[SYNC_DELAY-1];

    // Delay raw timing by SYNC_DELAY so it lines up with the pixel inputs.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hsync_sh     <= '0;
            vsync_sh     <= '0;
            active_sh    <= '0;
            new_frame_sh <= '0;
        end else begin
            hsync_sh[0]     <= vid.hsync_in;
            vsync_sh[0]     <= vid.vsync_in;
            active_sh[0]    <= vid.active_draw_in;
            new_frame_sh[0] <= vid.new_frame_in;
            for (int i = 1; i < SYNC_DELAY; i++) begin
                hsync_sh[i]     <= hsync_sh[i-1];
                vsync_sh[i]     <= vsync_sh[i-1];
                active_sh[i]    <= active_sh[i-1];
                new_frame_sh[i] <= new_frame_sh[i-1];
            end
        end
    end

    // Priority select: lowest valid layer wins, background otherwise, black in blanking.
    always_comb begin
        pix_sel = vid.bg_rgb_in;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (vid.layer_valid_in[i]) begin
                pix_sel = vid.layer_rgb_in[24*i +: 24];
            end
        end
        if (!a_active) begin
            pix_sel = 24'h0;
        end
    end

    // This pixel's overlap between layer 0 and each other layer; bit 0 never set.
    always_comb begin
        contrib = '0;
        for (int i = 1; i < NUM_LAYERS; i++) begin
            contrib[i] = a_active & vid.layer_valid_in[0] & vid.layer_valid_in[i];
        end
    end

    // Output register for the composited pixel and the realigned timing.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rgb_q    <= 24'h0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            active_q <= 1'b0;
        end else begin
            rgb_q    <= pix_sel;
            hsync_q  <= a_hsync;
            vsync_q  <= a_vsync;
            active_q <= a_active;
        end
    end

    // Frame-long overlap accumulation; the boundary pixel starts the new frame.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            acc     <= '0;
            mask_q  <= '0;
            frame_q <= 1'b0;
            count_q <= 16'h0;
        end else begin
            frame_q <= 1'b0;
            if (a_new_frame) begin
                mask_q  <= acc;
                frame_q <= 1'b1;
                acc     <= contrib;
                if ((acc != '0) && (count_q != 16'hFFFF)) begin
                    count_q <= count_q + 16'd1;
                end
            end else begin
                acc <= acc | contrib;
            end
        end
    end

    assign vid.red_out             = rgb_q[23:16];
    assign vid.green_out           = rgb_q[15:8];
    assign vid.blue_out            = rgb_q[7:0];
    assign vid.hsync_out           = hsync_q;
    assign vid.vsync_out           = vsync_q;
    assign vid.active_draw_out     = active_q;
    assign vid.collision_mask_out  = mask_q;
    assign vid.collision_frame_out = frame_q;
    assign vid.collision_count_out = count_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: reset, priority, blanking, timing
// delay, collision reporting, back-to-back frames, saturation, mid-frame reset.
module tb_sprite_compositor;

    logic pixel_clk_in;
    logic rst_n_in;
    int   checkCount;
    int   errorCount;

    sprite_compositor_if #(.NUM_LAYERS(4)) vid ();

    sprite_compositor #(
        .NUM_LAYERS(4),
        .SYNC_DELAY(4)
    ) dut (
        .pixel_clk_in(pixel_clk_in),
        .rst_n_in    (rst_n_in),
        .vid         (vid)
    );

    initial pixel_clk_in = 1'b0;
    always #5 pixel_clk_in = ~pixel_clk_in;

    // Compare one observed value against its hand-computed expectation.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Drive one cycle of inputs, clock it in, and settle just after the edge.
    task automatic applyStimulus(input logic active, input logic newFrame,
                                 input logic [3:0] valid);
        vid.active_draw_in = active;
        vid.new_frame_in   = newFrame;
        vid.layer_valid_in = valid;
        @(posedge pixel_clk_in);
        #1;
    endtask

    // Raw new_frame pulse; the fifth cycle carries the boundary pixel at stage A.
    task automatic doBoundary(input logic active, input logic [3:0] boundaryValid);
        applyStimulus(active, 1'b1, 4'b0000);
        repeat (3) applyStimulus(active, 1'b0, 4'b0000);
        applyStimulus(active, 1'b0, boundaryValid);
    endtask

    function automatic logic [31:0] rgbOut();
        return {8'h0, vid.red_out, vid.green_out, vid.blue_out};
    endfunction

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_rgb"},   rgbOut(), 32'h0);
        checkOutput({tag, "_sync"},  {29'h0, vid.hsync_out, vid.vsync_out, vid.active_draw_out}, 32'h0);
        checkOutput({tag, "_mask"},  {28'h0, vid.collision_mask_out}, 32'h0);
        checkOutput({tag, "_frame"}, {31'h0, vid.collision_frame_out}, 32'h0);
        checkOutput({tag, "_count"}, {16'h0, vid.collision_count_out}, 32'h0);
    endtask

    task automatic checkReport(input string tag, input logic frame,
                               input logic [3:0] mask, input logic [15:0] count);
        checkOutput({tag, "_frame"}, {31'h0, vid.collision_frame_out}, {31'h0, frame});
        checkOutput({tag, "_mask"},  {28'h0, vid.collision_mask_out}, {28'h0, mask});
        checkOutput({tag, "_count"}, {16'h0, vid.collision_count_out}, {16'h0, count});
    endtask

    initial begin
        checkCount = 0;
        errorCount = 0;
        vid.hcount_in      = 11'h0;
        vid.vcount_in      = 10'h0;
        vid.hsync_in       = 1'b0;
        vid.vsync_in       = 1'b0;
        vid.active_draw_in = 1'b0;
        vid.new_frame_in   = 1'b0;
        vid.bg_rgb_in      = 24'h0;
        vid.layer_rgb_in   = '0;
        vid.layer_valid_in = '0;
        rst_n_in = 1'b1;
        #2 rst_n_in = 1'b0;

        // Reset held with random inputs: every output stays zero.
        for (int k = 0; k < 6; k++) begin
            vid.hcount_in    = 11'($urandom);
            vid.vcount_in    = 10'($urandom);
            vid.hsync_in     = 1'($urandom);
            vid.vsync_in     = 1'($urandom);
            vid.bg_rgb_in    = 24'($urandom);
            vid.layer_rgb_in = {$urandom, $urandom, $urandom};
            applyStimulus(1'($urandom), 1'($urandom), 4'($urandom));
        end
        checkAllZero("reset");

        // Release: first real pixel appears SYNC_DELAY+1 cycles later.
        vid.hsync_in     = 1'b0;
        vid.vsync_in     = 1'b0;
        vid.bg_rgb_in    = 24'h445566;
        vid.layer_rgb_in = {24'hDEAD01, 24'hAABBCC, 24'h112233, 24'h778899};
        vid.active_draw_in = 1'b1;
        vid.new_frame_in   = 1'b0;
        vid.layer_valid_in = 4'b0000;
        rst_n_in = 1'b1;
        repeat (4) applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("release_rgb_early", rgbOut(), 32'h0);
        checkOutput("release_active_early", {31'h0, vid.active_draw_out}, 32'h0);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("release_rgb_bg", rgbOut(), 32'h00445566);
        checkOutput("release_active", {31'h0, vid.active_draw_out}, 32'h1);

        // Priority among valid layers.
        applyStimulus(1'b1, 1'b0, 4'b0110);
        checkOutput("prio_0110", rgbOut(), 32'h00112233);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("prio_bg", rgbOut(), 32'h00445566);
        applyStimulus(1'b1, 1'b0, 4'b1111);
        checkOutput("prio_1111", rgbOut(), 32'h00778899);
        applyStimulus(1'b1, 1'b0, 4'b1000);
        checkOutput("prio_1000", rgbOut(), 32'h00DEAD01);

        // Blanking: delayed active falls after four cycles, then rgb is black.
        repeat (4) applyStimulus(1'b0, 1'b0, 4'b0000);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("blank_rgb", rgbOut(), 32'h0);
        checkOutput("blank_active", {31'h0, vid.active_draw_out}, 32'h0);

        // A one-cycle hsync appears at the output five cycles later.
        vid.hsync_in = 1'b1;
        applyStimulus(1'b0, 1'b0, 4'b1111);
        vid.hsync_in = 1'b0;
        repeat (3) applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("hsync_t4", {31'h0, vid.hsync_out}, 32'h0);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("hsync_t5", {31'h0, vid.hsync_out}, 32'h1);
        checkOutput("blank_rgb2", rgbOut(), 32'h0);
        applyStimulus(1'b0, 1'b0, 4'b1111);
        checkOutput("hsync_t6", {31'h0, vid.hsync_out}, 32'h0);

        // First boundary reports the 4'b1111 pixel from the priority test.
        doBoundary(1'b1, 4'b0000);
        checkReport("b0", 1'b1, 4'b1110, 16'd1);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkReport("b0_hold", 1'b0, 4'b1110, 16'd1);

        // Player overlapping layer 3 for three pixels.
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b1001);
        doBoundary(1'b1, 4'b0000);
        checkReport("c1", 1'b1, 4'b1000, 16'd2);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkReport("c1_hold", 1'b0, 4'b1000, 16'd2);

        // Only layers 1 and 2 overlap: empty mask, pulse still issued.
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b0110);
        doBoundary(1'b1, 4'b0000);
        checkReport("c2", 1'b1, 4'b0000, 16'd2);

        // Overlap only during blanking is ignored.
        repeat (4) applyStimulus(1'b0, 1'b0, 4'b0000);
        repeat (3) applyStimulus(1'b0, 1'b0, 4'b1111);
        doBoundary(1'b1, 4'b0000);
        checkReport("c3", 1'b1, 4'b0000, 16'd2);

        // Overlap on the boundary pixel belongs to the following frame.
        doBoundary(1'b1, 4'b0101);
        checkReport("c4a", 1'b1, 4'b0000, 16'd2);
        doBoundary(1'b1, 4'b0000);
        checkReport("c4b", 1'b1, 4'b0100, 16'd3);

        // Back-to-back new_frame pulses latch independently.
        applyStimulus(1'b1, 1'b1, 4'b0000);
        applyStimulus(1'b1, 1'b1, 4'b0000);
        repeat (2) applyStimulus(1'b1, 1'b0, 4'b0000);
        applyStimulus(1'b1, 1'b0, 4'b1011);
        checkReport("btb1", 1'b1, 4'b0000, 16'd3);
        applyStimulus(1'b1, 1'b0, 4'b1001);
        checkReport("btb2", 1'b1, 4'b1010, 16'd4);
        applyStimulus(1'b1, 1'b0, 4'b0000);
        checkOutput("btb_pulse_end", {31'h0, vid.collision_frame_out}, 32'h0);
        doBoundary(1'b1, 4'b0000);
        checkReport("btb3", 1'b1, 4'b1000, 16'd5);

        // Every cycle a colliding boundary: count reaches and holds 16'hFFFF.
        for (int m = 1; m <= 65537; m++) begin
            applyStimulus(1'b1, 1'b1, 4'b1001);
            if (m == 65533) checkOutput("sat_fffe", {16'h0, vid.collision_count_out}, 32'h0000FFFE);
            if (m == 65534) checkOutput("sat_ffff", {16'h0, vid.collision_count_out}, 32'h0000FFFF);
        end
        checkReport("sat_hold", 1'b1, 4'b1000, 16'hFFFF);

        // Reset mid-frame: clean restart, first report covers the partial frame.
        applyStimulus(1'b1, 1'b0, 4'b1001);
        rst_n_in = 1'b0;
        #1;
        checkAllZero("midreset");
        applyStimulus(1'b1, 1'b0, 4'b1001);
        rst_n_in = 1'b1;
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1, 1'b0, 4'b0000);
            checkOutput("post_reset_no_pulse", {31'h0, vid.collision_frame_out}, 32'h0);
        end
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b1001);
        doBoundary(1'b1, 4'b0000);
        checkReport("partial", 1'b1, 4'b1000, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
